pll_lock_supervisor: RTL and testbench
======================================

// Module: pll_lock_supervisor
// PURPOSE
// - Parametrised lock supervisor and reset sequencer placed beside a multi-output PLL; runs on the free-running refclk.
// - Pulses PLL reset, qualifies lock (debounce + timeout), retries failed locks, then releases per-output-clock resets in staggered index order.
// - Detects lock loss or a software relock request in RUN, re-asserts all channel resets and restarts the PLL.
// - Consumers resynchronise their chan_rst_n bit into their own clock domain.
// PARAMETERS
// - NUM_CLOCKS       3       number of PLL output channels / chan_rst_n bits (1..18)
// - CNT_W            24      width of the shared cycle counter
// - RST_PULSE_CYC    16      refclk cycles pll_rst is held high per attempt (>=1)
// - LOCK_STABLE_CYC  1024    consecutive synced-lock cycles required to accept lock
// - LOCK_TIMEOUT_CYC 262144  max cycles in WAIT_LOCK before a retry; must be > LOCK_STABLE_CYC, < 2**CNT_W
// - STAGGER_CYC      8       cycles between successive channel reset releases (0 = release all together)
// - MAX_RETRIES      3       lock timeouts tolerated before FAIL (1..15)
// PORTS
// - refclk        in   1           reference clock, free-running
// - rst_n         in   1           asynchronous active-low reset
// - pll_locked    in   1           PLL locked, asynchronous; 2-flop synchronised internally
// - relock_req    in   1           refclk-synchronous; rising edge forces a PLL restart
// - pll_rst       out  1           PLL reset, active-high
// - chan_rst_n    out  NUM_CLOCKS  per-channel reset, active-low, registered
// - ready         out  1           all channels released, PLL locked
// - fail          out  1           sticky; lock not achieved within MAX_RETRIES attempts
// - retry_cnt     out  4           lock timeouts since last successful lock or relock_req
// BEHAVIOUR
// - Reset (rst_n low, async): pll_rst=1, chan_rst_n=0, ready=0, fail=0, retry_cnt=0, state=PULSE, cnt=0.
// - lk = pll_locked after 2 refclk flops; rq = relock_req rising edge (1 flop history).
// - PULSE: pll_rst=1 for exactly RST_PULSE_CYC cycles -> WAIT_LOCK, cnt=0, stable=0.
// - WAIT_LOCK: pll_rst=0; cnt++ each cycle; stable++ while lk=1, cleared to 0 on any lk=0 cycle.
//   - stable reaches LOCK_STABLE_CYC -> RELEASE, retry_cnt=0.
//   - else cnt reaches LOCK_TIMEOUT_CYC -> retry_cnt++; if retry_cnt==MAX_RETRIES -> FAIL, else -> PULSE.
// - RELEASE: chan_rst_n[i] goes high i*STAGGER_CYC cycles after entry (bit 0 on first cycle); ready=1 same cycle as bit NUM_CLOCKS-1; -> RUN.
// - RUN: holds outputs. lk=0 or rq -> next edge: chan_rst_n=0, ready=0, -> PULSE; retry_cnt unchanged.
// - lk=0 or rq in RELEASE: same as RUN. rq in WAIT_LOCK: -> PULSE, retry_cnt unchanged.
// - FAIL: fail=1, pll_rst=1 held, chan_rst_n=0; only rq exits: fail=0, retry_cnt=0, -> PULSE.
// - Lock-drop latency in RUN: chan_rst_n low on 3rd refclk edge after pll_locked falls.
// - Simultaneous lk drop and rq: single restart, one pll_rst pulse of RST_PULSE_CYC.
// - retry_cnt never exceeds MAX_RETRIES; counters never wrap (parameter limits above).
// - rst_n mid-operation: all outputs to reset values immediately, sequence restarts from PULSE.
// CONFIGURATION
// - LOCK_LOSS_CNT_EN defined: extra port lock_loss_cnt out 8; increments (saturates at 255) on every RUN/RELEASE exit caused by lk=0, incl. when coincident with rq; rq-only exits do not count; cleared only by rst_n.
// - Not defined: port and counter absent; all other behaviour identical.
// TESTING (NUM_CLOCKS=3, RST_PULSE_CYC=4, LOCK_STABLE_CYC=8, LOCK_TIMEOUT_CYC=64, STAGGER_CYC=2, MAX_RETRIES=3)
// - Power-up, pll_locked high from cycle 10 -> pll_rst high 4 cycles; chan_rst_n 001 after 8 stable lk cycles, 011 +2, 111 +4 with ready=1.
// - pll_locked high 5 cycles, low 1, high -> no release until 8 consecutive lk cycles after the glitch; retry_cnt=0.
// - pll_locked never high -> 3 pll_rst pulses, retry_cnt 1,2,3, fail=1, pll_rst held; relock_req -> fail=0, retry_cnt=0, 4-cycle pulse.
// - In RUN drop pll_locked -> chan_rst_n=000, ready=0 on 3rd edge, 4-cycle pll_rst pulse; lock_loss_cnt=1 (macro on).
// - In RUN relock_req rise same cycle lk drops -> exactly one 4-cycle pulse; lock_loss_cnt +1; retry_cnt unchanged.
// - rst_n low while chan_rst_n=011 -> immediately pll_rst=1, chan_rst_n=000, ready=0; lock_loss_cnt=0.

Source files
------------

// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor
//   Lock supervisor and reset sequencer for a multi-output PLL. It runs on
//   the free-running refclk and performs these steps:
//     1. Pulse the PLL reset.
//     2. Qualify pll_locked with a debounce window and a timeout, retrying
//        after each timeout.
//     3. Release the per-channel resets one at a time, in index order.
//   A lock drop or a relock_req rising edge during RELEASE/RUN re-asserts
//   every channel reset and restarts the PLL. Consumers resynchronise their
//   chan_rst_n bit into their own clock domain.
//
// Ports
//   refclk        in   free-running reference clock
//   rst_n         in   async active-low reset
//   pll_locked    in   async PLL lock, 2-flop synchronised here
//   relock_req    in   refclk-synchronous, rising edge forces a restart
//   pll_rst       out  PLL reset, active-high, registered
//   chan_rst_n    out  per-channel active-low resets, registered
//   ready         out  all channels released with the PLL locked
//   fail          out  sticky; lock not reached within MAX_RETRIES attempts
//   retry_cnt     out  lock timeouts since last good lock / relock_req
//   lock_loss_cnt out  (LOCK_LOSS_CNT_EN only) saturating count of exits
//                      from RELEASE/RUN caused by lock loss
//
// Build option: define LOCK_LOSS_CNT_EN to add lock_loss_cnt.

module pll_lock_supervisor_lane #(
    parameter int              CNT_W  = 24,
    parameter logic [CNT_W-1:0] REL_AT = '0
) (
    input  logic             refclk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             rel_en,
    input  logic [CNT_W-1:0] rel_t,
    output logic             chan_rst_n
);
    // Bit is released once the release timeline passes this lane's slot
    // and stays released until the supervisor clears all lanes.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n)                        chan_rst_n <= 1'b0;
        else if (clr)                      chan_rst_n <= 1'b0;
        else if (rel_en && rel_t >= REL_AT) chan_rst_n <= 1'b1;
    end
endmodule

module pll_lock_supervisor #(
    parameter int NUM_CLOCKS       = 3,
    parameter int CNT_W            = 24,
    parameter int RST_PULSE_CYC    = 16,
    parameter int LOCK_STABLE_CYC  = 1024,
    parameter int LOCK_TIMEOUT_CYC = 262144,
    parameter int STAGGER_CYC      = 8,
    parameter int MAX_RETRIES      = 3
) (
    input  logic                  refclk,
    input  logic                  rst_n,
    input  logic                  pll_locked,
    input  logic                  relock_req,
    output logic                  pll_rst,
    output logic [NUM_CLOCKS-1:0] chan_rst_n,
    output logic                  ready,
    output logic                  fail,
    output logic [3:0]            retry_cnt
`ifdef LOCK_LOSS_CNT_EN
    ,
    output logic [7:0]            lock_loss_cnt
`endif
);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(RST_PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] STABLE     = CNT_W'(LOCK_STABLE_CYC);
    localparam logic [CNT_W-1:0] TIMEOUT    = CNT_W'(LOCK_TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] LAST_REL   = CNT_W'((NUM_CLOCKS - 1) * STAGGER_CYC);
    localparam logic [3:0]       MAXR       = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {S_PULSE, S_WAIT, S_REL, S_RUN, S_FAIL} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, stable_q, stable_d, rel_t;
    logic [3:0]       retry_q, retry_d;
    logic             ready_q, ready_d, pll_rst_q, pll_rst_d, fail_q, fail_d;
    logic             lk_meta, lk, rq_hist, rq;
    logic             rel_en, chan_clr;

    assign rq = relock_req & ~rq_hist;

    // State register (with the datapath it owns) and input synchronisers.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_PULSE;
            cnt_q     <= '0;
            stable_q  <= '0;
            retry_q   <= '0;
            ready_q   <= 1'b0;
            pll_rst_q <= 1'b1;
            fail_q    <= 1'b0;
            lk_meta   <= 1'b0;
            lk        <= 1'b0;
            rq_hist   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            stable_q  <= stable_d;
            retry_q   <= retry_d;
            ready_q   <= ready_d;
            pll_rst_q <= pll_rst_d;
            fail_q    <= fail_d;
            lk_meta   <= pll_locked;
            lk        <= lk_meta;
            rq_hist   <= relock_req;
        end
    end

    // Next-state logic. cnt is shared: pulse length in PULSE, timeout in
    // WAIT, release timeline in RELEASE.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        retry_d  = retry_q;
        ready_d  = ready_q;
        rel_en   = 1'b0;
        rel_t    = '0;
        chan_clr = 1'b0;
        unique case (state_q)
            S_PULSE: begin
                if (cnt_q == PULSE_LAST) begin
                    state_d  = S_WAIT;
                    cnt_d    = '0;
                    stable_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT: begin
                cnt_d    = cnt_q + 1'b1;
                stable_d = lk ? stable_q + 1'b1 : '0;
                if (rq) begin
                    state_d = S_PULSE;
                    cnt_d   = '0;
                end else if (stable_d == STABLE) begin
                    // Channel 0 is released on the same edge that accepts lock.
                    state_d = S_REL;
                    cnt_d   = '0;
                    retry_d = '0;
                    rel_en  = 1'b1;
                    if (LAST_REL == '0) begin
                        state_d = S_RUN;
                        ready_d = 1'b1;
                    end
                end else if (cnt_d == TIMEOUT) begin
                    retry_d = retry_q + 1'b1;
                    cnt_d   = '0;
                    state_d = (retry_d == MAXR) ? S_FAIL : S_PULSE;
                end
            end
            S_REL, S_RUN: begin
                if (!lk || rq) begin
                    state_d  = S_PULSE;
                    cnt_d    = '0;
                    chan_clr = 1'b1;
                    ready_d  = 1'b0;
                end else if (state_q == S_REL) begin
                    cnt_d  = cnt_q + 1'b1;
                    rel_en = 1'b1;
                    rel_t  = cnt_d;
                    if (cnt_d == LAST_REL) begin
                        state_d = S_RUN;
                        ready_d = 1'b1;
                    end
                end
            end
            S_FAIL: begin
                if (rq) begin
                    state_d = S_PULSE;
                    cnt_d   = '0;
                    retry_d = '0;
                end
            end
            default: begin
                state_d = S_PULSE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output decode from the next state, registered so pll_rst never glitches.
    always_comb begin
        pll_rst_d = (state_d == S_PULSE) || (state_d == S_FAIL);
        fail_d    = (state_d == S_FAIL);
    end

    for (genvar i = 0; i < NUM_CLOCKS; i++) begin : g_lane
        pll_lock_supervisor_lane #(
            .CNT_W (CNT_W),
            .REL_AT(CNT_W'(i * STAGGER_CYC))
        ) u_lane (
            .refclk    (refclk),
            .rst_n     (rst_n),
            .clr       (chan_clr),
            .rel_en    (rel_en),
            .rel_t     (rel_t),
            .chan_rst_n(chan_rst_n[i])
        );
    end

    assign pll_rst   = pll_rst_q;
    assign ready     = ready_q;
    assign fail      = fail_q;
    assign retry_cnt = retry_q;

`ifdef LOCK_LOSS_CNT_EN
    logic lost_exit;
    assign lost_exit = ((state_q == S_REL) || (state_q == S_RUN)) && !lk;

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n)                               lock_loss_cnt <= '0;
        else if (lost_exit && lock_loss_cnt != 8'hFF) lock_loss_cnt <= lock_loss_cnt + 8'd1;
    end
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
module tb_pll_lock_supervisor;
    localparam int N = 3, CW = 24, RP = 4, LS = 8, LT = 64, ST = 2, MR = 3;

    logic         refclk = 1'b0, rst_n = 1'b0, pll_locked = 1'b0, relock_req = 1'b0;
    logic         pll_rst, ready, fail;
    logic [N-1:0] chan_rst_n;
    logic [3:0]   retry_cnt;
`ifdef LOCK_LOSS_CNT_EN
    logic [7:0]   lock_loss_cnt;
`endif

    int n_tests = 0, n_fail = 0, n_prints = 0, cyc = 0;

    pll_lock_supervisor #(
        .NUM_CLOCKS(N), .CNT_W(CW), .RST_PULSE_CYC(RP), .LOCK_STABLE_CYC(LS),
        .LOCK_TIMEOUT_CYC(LT), .STAGGER_CYC(ST), .MAX_RETRIES(MR)
    ) dut (
        .refclk(refclk), .rst_n(rst_n), .pll_locked(pll_locked), .relock_req(relock_req),
        .pll_rst(pll_rst), .chan_rst_n(chan_rst_n), .ready(ready), .fail(fail),
        .retry_cnt(retry_cnt)
`ifdef LOCK_LOSS_CNT_EN
        , .lock_loss_cnt(lock_loss_cnt)
`endif
    );

    always #5 refclk = ~refclk;
    always @(posedge refclk) cyc <= cyc + 1;

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            if (n_prints < 40) begin
                n_prints++;
                $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
            end
        end
    endtask

    // Behavioural model: a phase name plus elapsed-cycle counts; outputs are
    // derived from the phase and the position on the release timeline.
    string m_mode;
    int    m_el, m_stab, m_rel, m_retries, m_losses;
    logic  m_s1, m_s2, m_rqp;

    task automatic model_reset();
        m_mode = "pulse"; m_el = 0; m_stab = 0; m_rel = 0;
        m_retries = 0; m_losses = 0; m_s1 = 0; m_s2 = 0; m_rqp = 0;
    endtask

    task automatic model_step();
        logic lk, rq;
        lk = m_s2;
        rq = relock_req && !m_rqp;
        m_s2 = m_s1; m_s1 = pll_locked; m_rqp = relock_req;
        if (m_mode == "pulse") begin
            m_el++;
            if (m_el == RP) begin m_mode = "wait"; m_el = 0; m_stab = 0; end
        end else if (m_mode == "wait") begin
            if (rq) begin
                m_mode = "pulse"; m_el = 0;
            end else begin
                m_el++;
                m_stab = lk ? m_stab + 1 : 0;
                if (m_stab == LS) begin
                    m_retries = 0; m_rel = 0;
                    m_mode = ((N - 1) * ST == 0) ? "run" : "release";
                end else if (m_el == LT) begin
                    m_retries++; m_el = 0;
                    m_mode = (m_retries == MR) ? "fail" : "pulse";
                end
            end
        end else if (m_mode == "release" || m_mode == "run") begin
            if (!lk || rq) begin
                if (!lk && m_losses < 255) m_losses++;
                m_mode = "pulse"; m_el = 0;
            end else if (m_mode == "release") begin
                m_rel++;
                if (m_rel >= (N - 1) * ST) m_mode = "run";
            end
        end else if (m_mode == "fail") begin
            if (rq) begin m_retries = 0; m_mode = "pulse"; m_el = 0; end
        end
    endtask

    function automatic logic [N-1:0] exp_chan();
        logic [N-1:0] v = '0;
        for (int i = 0; i < N; i++)
            if (m_mode == "run" || (m_mode == "release" && i * ST <= m_rel)) v[i] = 1'b1;
        return v;
    endfunction

    initial begin
        model_reset();
        forever begin
            @(posedge refclk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    // Every-cycle compare against the model.
    initial forever begin
        @(negedge refclk);
        chk("m_pll_rst", pll_rst, (m_mode == "pulse" || m_mode == "fail"));
        chk("m_fail",    fail,    (m_mode == "fail"));
        chk("m_ready",   ready,   (m_mode == "run"));
        chk("m_chan",    chan_rst_n, exp_chan());
        chk("m_retry",   retry_cnt,  m_retries);
`ifdef LOCK_LOSS_CNT_EN
        chk("m_loss",    lock_loss_cnt, m_losses);
`endif
    end

    task automatic at(int t);
        while (cyc < t) @(negedge refclk);
    endtask

    int b, c, c1, c2, d, b2;

    initial begin
        repeat (2) @(negedge refclk);
        chk("rst_pll_rst", pll_rst, 1);
        chk("rst_chan",    chan_rst_n, 0);
        chk("rst_ready",   ready, 0);
        chk("rst_fail",    fail, 0);
        chk("rst_retry",   retry_cnt, 0);
        rst_n = 1'b1;
        b = cyc;

        // Power-up, lock from cycle 10.
        at(b + 3);  chk("pu_rst_hi", pll_rst, 1);
        at(b + 4);  chk("pu_rst_lo", pll_rst, 0);
        at(b + 9);  pll_locked = 1'b1;
        at(b + 18); chk("pu_chan_18", chan_rst_n, 3'b000);
        at(b + 19); chk("pu_chan_19", chan_rst_n, 3'b001);
        at(b + 21); chk("pu_chan_21", chan_rst_n, 3'b011);
        at(b + 22); chk("pu_rdy_22", ready, 0);
        at(b + 23); chk("pu_chan_23", chan_rst_n, 3'b111); chk("pu_rdy_23", ready, 1);

        // Lock drop in RUN.
        c = b + 30;
        at(c);      pll_locked = 1'b0;
        at(c + 2);  chk("drop_chan_2", chan_rst_n, 3'b111);
        at(c + 3);  chk("drop_chan_3", chan_rst_n, 3'b000); chk("drop_rdy", ready, 0);
                    chk("drop_rst_3", pll_rst, 1);
        at(c + 6);  chk("drop_rst_6", pll_rst, 1);
        at(c + 7);  chk("drop_rst_7", pll_rst, 0);
`ifdef LOCK_LOSS_CNT_EN
        chk("drop_loss", lock_loss_cnt, 1);
`endif

        // Glitch during qualification.
        c1 = c + 8;
        at(c1);      pll_locked = 1'b1;
        at(c1 + 5);  pll_locked = 1'b0;
        at(c1 + 6);  pll_locked = 1'b1;
        at(c1 + 12); chk("gl_chan_12", chan_rst_n, 3'b000);
        at(c1 + 15); chk("gl_chan_15", chan_rst_n, 3'b000);
        at(c1 + 16); chk("gl_chan_16", chan_rst_n, 3'b001); chk("gl_retry", retry_cnt, 0);
        at(c1 + 20); chk("gl_rdy", ready, 1);

        // relock_req rising with the synced lock drop: one restart.
        c2 = c1 + 30;
        at(c2);      pll_locked = 1'b0;
        at(c2 + 2);  relock_req = 1'b1; chk("co_chan_2", chan_rst_n, 3'b111);
        at(c2 + 3);  relock_req = 1'b0; chk("co_chan_3", chan_rst_n, 3'b000);
                     chk("co_rst_3", pll_rst, 1);
        at(c2 + 6);  chk("co_rst_6", pll_rst, 1);
        at(c2 + 7);  chk("co_rst_7", pll_rst, 0); chk("co_retry", retry_cnt, 0);
        at(c2 + 8);  chk("co_rst_8", pll_rst, 0);
`ifdef LOCK_LOSS_CNT_EN
        chk("co_loss", lock_loss_cnt, 2);
`endif

        // Lock never comes back: three timeouts then FAIL.
        at(c2 + 70);  chk("to_retry_70", retry_cnt, 0); chk("to_rst_70", pll_rst, 0);
        at(c2 + 71);  chk("to_retry_71", retry_cnt, 1); chk("to_rst_71", pll_rst, 1);
        at(c2 + 139); chk("to_retry_139", retry_cnt, 2);
        at(c2 + 206); chk("to_fail_206", fail, 0);
        at(c2 + 207); chk("to_fail_207", fail, 1); chk("to_retry_207", retry_cnt, 3);
                      chk("to_rst_207", pll_rst, 1);
        at(c2 + 240); chk("to_fail_240", fail, 1); chk("to_rst_240", pll_rst, 1);

        // relock_req leaves FAIL.
        d = c2 + 250;
        at(d);      relock_req = 1'b1;
        at(d + 1);  relock_req = 1'b0; pll_locked = 1'b1;
                    chk("fx_fail", fail, 0); chk("fx_retry", retry_cnt, 0); chk("fx_rst_1", pll_rst, 1);
        at(d + 4);  chk("fx_rst_4", pll_rst, 1);
        at(d + 5);  chk("fx_rst_5", pll_rst, 0);
        at(d + 13); chk("fx_chan_13", chan_rst_n, 3'b001);

        // Async reset while partially released.
        at(d + 15); chk("ar_chan_pre", chan_rst_n, 3'b011);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_pll_rst", pll_rst, 1); chk("ar_chan", chan_rst_n, 0); chk("ar_ready", ready, 0);
`ifdef LOCK_LOSS_CNT_EN
        chk("ar_loss", lock_loss_cnt, 0);
`endif
        @(negedge refclk);
        rst_n = 1'b1;
        b2 = cyc;
        at(b2 + 11); chk("rr_chan_11", chan_rst_n, 3'b000);
        at(b2 + 12); chk("rr_chan_12", chan_rst_n, 3'b001);
        at(b2 + 16); chk("rr_rdy", ready, 1);

        // relock_req alone in RUN: restart without a lock-loss count.
        at(b2 + 20); relock_req = 1'b1;
        at(b2 + 21); relock_req = 1'b0;
                     chk("rq_chan", chan_rst_n, 0); chk("rq_rst", pll_rst, 1);
`ifdef LOCK_LOSS_CNT_EN
        chk("rq_loss", lock_loss_cnt, 0);
`endif
        at(b2 + 40);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
